// File: rtl/itch_arb_pkg.sv
// itch_arb_pkg: shared constants, types and helpers for the ITCH decoder
// arbiter slice.
//   - CH_* : channel ids of the decoder bank feeding the arbiter.
//   - DEFAULT_PAYLOAD_W : default width of a decoder payload bus.
//   - DROP_CNT_W / TS_W : widths of the drop counter and ingress timestamp.
//   - arb_entry_t : one arbitrated message {ch_id, payload, ts} at default sizes.
//   - sat_add_drops : saturating add used by the drop counter.
package itch_arb_pkg;

  localparam int CH_ADD     = 0;
  localparam int CH_CANCEL  = 1;
  localparam int CH_DELETE  = 2;
  localparam int CH_REPLACE = 3;
  localparam int CH_EXEC    = 4;
  localparam int CH_TRADE   = 5;

  localparam int DEFAULT_PAYLOAD_W = 256;
  localparam int DROP_CNT_W        = 16;
  localparam int TS_W              = 32;
  // Channel tag wide enough for the largest supported bank (16 channels).
  localparam int ENTRY_CH_ID_W     = 4;

  typedef struct packed {
    logic [ENTRY_CH_ID_W-1:0]     ch_id;
    logic [DEFAULT_PAYLOAD_W-1:0] payload;
    logic [TS_W-1:0]              ts;
  } arb_entry_t;

  // At most 16 channels can drop in one cycle, so the increment fits 5 bits.
  function automatic logic [DROP_CNT_W-1:0] sat_add_drops(
    input logic [DROP_CNT_W-1:0] count,
    input logic [4:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, count} + {{(DROP_CNT_W-4){1'b0}}, inc};
    return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/itch_arb_fifo.sv
// itch_arb_fifo: synchronous FIFO with a register-array store.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push/push_data: write request; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   pop           : remove the head; ignored when empty
//   pop_data      : current head entry (meaningful only when !empty)
//   level         : occupancy 0..DEPTH
//   full, empty   : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module itch_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/itch_decoder_arbiter.sv
// itch_decoder_arbiter: merges per-type ITCH decoder outputs into one tagged,
// flow-controlled stream. Each channel has a one-entry hold register; a
// round-robin arbiter moves held messages into a shared FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   ch_valid     : per-channel one-cycle message pulse
//   ch_payload   : packed payloads, channel i at [i*PAYLOAD_W +: PAYLOAD_W]
//   out_valid/out_ready/out_ch_id/out_payload/out_ts : output stream
//   drop_count   : saturating count of messages lost to a full hold register
//   overflow     : sticky, set on the first drop
//   fifo_level   : FIFO occupancy
// Optional feature macro: ITCH_ARB_TIMESTAMP_EN adds a free-running 32-bit
// cycle counter captured at ingress and returned on out_ts; otherwise out_ts=0.
//
// Handshake: the head entry transfers on a rising edge where
// out_valid && out_ready; while out_valid && !out_ready every out_* field holds
// steady, and out_valid never drops without a transfer (except on reset).
module itch_decoder_arbiter
  import itch_arb_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int PAYLOAD_W  = DEFAULT_PAYLOAD_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_ID_W    = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*PAYLOAD_W-1:0]   ch_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_ID_W-1:0]            out_ch_id,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [31:0]                   out_ts,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef ITCH_ARB_TIMESTAMP_EN
  localparam int ENTRY_W = CH_ID_W + PAYLOAD_W + TS_W;
`else
  localparam int ENTRY_W = CH_ID_W + PAYLOAD_W;
`endif

  logic [NUM_CH-1:0]    hold_full;
  logic [PAYLOAD_W-1:0] hold_payload [NUM_CH];
  logic [CH_ID_W-1:0]   rr_ptr;
  logic [CH_ID_W-1:0]   grant_idx;
  logic                 grant_found;
  logic                 grant_valid;
  logic [NUM_CH-1:0]    grant_vec;
  logic [NUM_CH-1:0]    capture;
  logic [NUM_CH-1:0]    drop;
  logic [4:0]           n_drops;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   head;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Round-robin search starting at rr_ptr; first full hold register wins.
  always_comb begin
    int j;
    logic [CH_ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      idx = CH_ID_W'(j);
      if (!grant_found && hold_full[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    // A full FIFO can still accept when its head leaves this cycle.
    grant_valid = grant_found && (!fifo_full || pop);
    grant_vec   = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // A full hold register that is granted this cycle frees up in time to
  // take a new message on the same edge.
  always_comb begin
    n_drops = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      capture[i] = ch_valid[i] && (!hold_full[i] || grant_vec[i]);
      drop[i]    = ch_valid[i] && hold_full[i] && !grant_vec[i];
      n_drops    = n_drops + 5'(drop[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full  <= '0;
      rr_ptr     <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hold_payload[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          hold_full[i]    <= 1'b1;
          hold_payload[i] <= ch_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end else if (grant_vec[i]) begin
          hold_full[i] <= 1'b0;
        end
      end
      if (grant_valid)
        rr_ptr <= (grant_idx == CH_ID_W'(NUM_CH-1)) ? '0 : grant_idx + CH_ID_W'(1);
      if (|drop) begin
        drop_count <= sat_add_drops(drop_count, n_drops);
        overflow   <= 1'b1;
      end
    end
  end

`ifdef ITCH_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] hold_ts [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_ts[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      for (int i = 0; i < NUM_CH; i++)
        if (capture[i]) hold_ts[i] <= ts_cnt;
    end
  end

  assign push_data = {grant_idx, hold_payload[grant_idx], hold_ts[grant_idx]};
  assign out_ts    = out_valid ? head[TS_W-1:0] : '0;
`else
  assign push_data = {grant_idx, hold_payload[grant_idx]};
  assign out_ts    = '0;
`endif

  // Outputs read zero whenever the FIFO is empty, including right after reset.
  assign out_ch_id   = out_valid ? head[ENTRY_W-1 -: CH_ID_W] : '0;
  assign out_payload = out_valid ? head[ENTRY_W-CH_ID_W-1 -: PAYLOAD_W] : '0;

  itch_arb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_itch_decoder_arbiter.sv
// tb_itch_decoder_arbiter: self-checking bench for itch_decoder_arbiter at
// default parameters. Expected {ch_id, payload} entries are queued when
// stimulus is driven and compared as the DUT presents them.
module tb_itch_decoder_arbiter;
  import itch_arb_pkg::*;

  localparam int NUM_CH = 6;
  localparam int PW     = 256;
  localparam int CW     = 3;
  localparam int EW     = CW + PW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_CH-1:0]      ch_valid = '0;
  logic [NUM_CH*PW-1:0]   ch_payload = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [CW-1:0]          out_ch_id;
  logic [PW-1:0]          out_payload;
  logic [31:0]            out_ts;
  logic [15:0]            drop_count;
  logic                   overflow;
  logic [3:0]             fifo_level;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [15:0]   exp_drops = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  itch_decoder_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_payload  (ch_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch_id   (out_ch_id),
    .out_payload (out_payload),
    .out_ts      (out_ts),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  // ---------------- drivers ----------------
  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] r;
    for (int w = 0; w < PW/32; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  task automatic drive_ch(input int ch, input logic [PW-1:0] p);
    ch_valid = ch_valid | (NUM_CH'(1) << ch);
    ch_payload[ch*PW +: PW] = p;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_ch_id !== '0) $display("FAIL reset_out_ch_id: got %0d required 0", out_ch_id); else n_pass++;
    n_checks++; if (out_payload !== '0) $display("FAIL reset_out_payload: got %h required 0", out_payload); else n_pass++;
    n_checks++; if (out_ts !== '0) $display("FAIL reset_out_ts: got %0d required 0", out_ts); else n_pass++;
    n_checks++; if (drop_count !== '0) $display("FAIL reset_drop_count: got %0d required 0", drop_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else n_pass++;
    n_checks++; if (fifo_level !== '0) $display("FAIL reset_fifo_level: got %0d required 0", fifo_level); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [PW-1:0] p;
    logic [EW-1:0] exp, got;
    p = '0;
    p[PW-1 -: 16] = 16'hDEAD;
    p[15:0] = 16'h0001;
    out_ready = 1'b1;
    @(negedge clk);
    drive_ch(CH_DELETE, p);
    exp_q.push_back({CW'(CH_DELETE), p});
    @(negedge clk);
    ch_valid = '0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_t1_valid: got %b required 0", out_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_t2_valid: got %b required 1", out_valid); else n_pass++;
    got = {out_ch_id, out_payload};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) $display("FAIL single_data: got ch=%0d payload=%h required ch=%0d payload=%h", got[EW-1 -: CW], got[PW-1:0], exp[EW-1 -: CW], exp[PW-1:0]);
    else n_pass++;
    n_checks++; if (drop_count !== '0) $display("FAIL single_drops: got %0d required 0", drop_count); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_t3_valid: got %b required 0", out_valid); else n_pass++;
  endtask

  task automatic test_simultaneous(input int start);
    logic [PW-1:0] ps [NUM_CH];
    logic [PW-1:0] p;
    logic [EW-1:0] exp, got;
    int c, ch, first_c, last_c;
    out_ready = 1'b1;
    // A lone message on the channel before 'start' leaves rr_ptr at 'start'.
    @(negedge clk);
    ch = (start + NUM_CH - 1) % NUM_CH;
    p = rand_payload();
    drive_ch(ch, p);
    exp_q.push_back({CW'(ch), p});
    @(negedge clk);
    ch_valid = '0;
    c = 0;
    while (exp_q.size() > 0 && c < 20) begin
      if (out_valid) begin
        got = {out_ch_id, out_payload};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL simul_setup_%0d: got ch=%0d required ch=%0d", start, got[EW-1 -: CW], exp[EW-1 -: CW]);
        else n_pass++;
      end
      @(negedge clk);
      c++;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      ps[i] = rand_payload();
      drive_ch(i, ps[i]);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      ch = (start + k) % NUM_CH;
      exp_q.push_back({CW'(ch), ps[ch]});
    end
    @(negedge clk);
    ch_valid = '0;
    c = 0; first_c = -1; last_c = -1;
    while (exp_q.size() > 0 && c < 30) begin
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        got = {out_ch_id, out_payload};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL simul_order_%0d: got ch=%0d payload=%h required ch=%0d payload=%h", start, got[EW-1 -: CW], got[PW-1:0], exp[EW-1 -: CW], exp[PW-1:0]);
        else n_pass++;
      end
      @(negedge clk);
      c++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL simul_timeout_%0d: %0d entries missing, required 0", start, exp_q.size()); else n_pass++;
    n_checks++; if (last_c - first_c != NUM_CH - 1) $display("FAIL simul_back_to_back_%0d: span %0d cycles required %0d", start, last_c - first_c, NUM_CH - 1); else n_pass++;
    n_checks++; if (drop_count !== exp_drops) $display("FAIL simul_drops_%0d: got %0d required %0d", start, drop_count, exp_drops); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p;
    logic [EW-1:0] exp, got;
    int c;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      p = rand_payload();
      drive_ch(CH_ADD, p);
      if (k < 9) exp_q.push_back({CW'(CH_ADD), p});
    end
    @(negedge clk);
    ch_valid = '0;
    exp_drops = 16'd1;
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL bp_level: got %0d required 8", fifo_level); else n_pass++;
    n_checks++; if (drop_count !== exp_drops) $display("FAIL bp_drop_count: got %0d required %0d", drop_count, exp_drops); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b required 1", overflow); else n_pass++;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      got = {out_ch_id, out_payload};
      n_checks++;
      if (!out_valid || got !== exp_q[0]) $display("FAIL bp_head_stall: valid=%b got ch=%0d payload=%h required ch=%0d payload=%h", out_valid, got[EW-1 -: CW], got[PW-1:0], exp_q[0][EW-1 -: CW], exp_q[0][PW-1:0]);
      else n_pass++;
    end
    out_ready = 1'b1;
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      if (out_valid) begin
        got = {out_ch_id, out_payload};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL bp_order: got payload=%h required payload=%h", got[PW-1:0], exp[PW-1:0]);
        else n_pass++;
      end
      @(negedge clk);
      c++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL bp_timeout: %0d entries missing, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (drop_count !== exp_drops) $display("FAIL bp_drops_after: got %0d required %0d", drop_count, exp_drops); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [PW-1:0] p;
    logic [EW-1:0] exp, got;
    int c;
    out_ready = 1'b0;
    // Nine pulses: eight land in the FIFO, the ninth waits in hold 1.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      p = rand_payload();
      drive_ch(CH_CANCEL, p);
      exp_q.push_back({CW'(CH_CANCEL), p});
    end
    @(negedge clk);
    n_checks++; if (fifo_level !== 4'd8) $display("FAIL full_fill_level: got %0d required 8", fifo_level); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) begin
        got = {out_ch_id, out_payload};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL full_order: got payload=%h required payload=%h", got[PW-1:0], exp[PW-1:0]);
        else n_pass++;
      end
      p = rand_payload();
      drive_ch(CH_CANCEL, p);
      exp_q.push_back({CW'(CH_CANCEL), p});
      @(negedge clk);
      n_checks++; if (fifo_level !== 4'd8) $display("FAIL full_level_hold: got %0d required 8", fifo_level); else n_pass++;
    end
    ch_valid = '0;
    c = 0;
    while (exp_q.size() > 0 && c < 40) begin
      if (out_valid) begin
        got = {out_ch_id, out_payload};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL full_drain_order: got payload=%h required payload=%h", got[PW-1:0], exp[PW-1:0]);
        else n_pass++;
      end
      @(negedge clk);
      c++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL full_timeout: %0d entries missing, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (drop_count !== exp_drops) $display("FAIL full_no_drop: got %0d required %0d", drop_count, exp_drops); else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ch_valid = '0;
      drive_ch(CH_DELETE, rand_payload());
    end
    @(negedge clk);
    ch_valid = '0;
    drive_ch(CH_ADD, rand_payload());
    drive_ch(CH_CANCEL, rand_payload());
    @(negedge clk);
    ch_valid = '0;
    n_checks++; if (fifo_level !== 4'd5) $display("FAIL rstmid_pre_level: got %0d required 5", fifo_level); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b required 0", out_valid); else n_pass++;
    n_checks++; if (fifo_level !== '0) $display("FAIL rstmid_level: got %0d required 0", fifo_level); else n_pass++;
    n_checks++; if (out_payload !== '0) $display("FAIL rstmid_payload: got %h required 0", out_payload); else n_pass++;
    n_checks++; if (out_ch_id !== '0) $display("FAIL rstmid_ch_id: got %0d required 0", out_ch_id); else n_pass++;
    n_checks++; if (drop_count !== '0) $display("FAIL rstmid_drops: got %0d required 0", drop_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b required 0", overflow); else n_pass++;
    exp_q.delete();
    exp_drops = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || fifo_level !== '0) $display("FAIL rstmid_stale: valid=%b level=%0d required 0/0", out_valid, fifo_level);
      else n_pass++;
    end
  endtask

  task automatic test_timestamp();
    logic [PW-1:0] p;
    logic [EW-1:0] exp, got;
    logic [31:0] exp_ts;
    int c;
`ifdef ITCH_ARB_TIMESTAMP_EN
    exp_ts = 32'd100;
`else
    exp_ts = 32'd0;
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    // 100 rising edges after release the cycle counter reads 100.
    repeat (100) @(negedge clk);
    p = rand_payload();
    drive_ch(CH_REPLACE, p);
    exp_q.push_back({CW'(CH_REPLACE), p});
    @(negedge clk);
    ch_valid = '0;
    c = 0;
    while (exp_q.size() > 0 && c < 20) begin
      if (out_valid) begin
        got = {out_ch_id, out_payload};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) $display("FAIL ts_data: got ch=%0d required ch=%0d", got[EW-1 -: CW], exp[EW-1 -: CW]);
        else n_pass++;
        n_checks++;
        if (out_ts !== exp_ts) $display("FAIL ts_value: got %0d required %0d", out_ts, exp_ts);
        else n_pass++;
      end
      @(negedge clk);
      c++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL ts_timeout: %0d entries missing, required 0", exp_q.size()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_simultaneous(0);
    test_simultaneous(4);
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_timestamp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
